iir1_mux_filter: RTL
====================

// Module: iir1_mux_filter
// PURPOSE
//  Time-multiplexed first-order shift-based IIR filter bank, N_CH channels sharing one datapath.
//  Per-channel mode: bypass / low-pass / high-pass / hold; per-channel time constant 8 ns*2**tau.
//  Sits between ADC/demod outputs and the PID/scope muxes; a sample vector is accepted via a valid/ready handshake.
// PARAMETERS
//  R      14  signed data width of each channel sample
//  N_CH   4   number of channels (>=1)
//  S      58  signed accumulator width; TAU_MAX = S-R-2 (42 at defaults)
// PORTS
//  clk       in   1         clock
//  rst       in   1         synchronous, active-high reset
//  in_valid  in   1         sample vector present
//  in_ready  out  1         block can accept a vector this cycle
//  in_data   in   N_CH*R    packed signed samples, ch k at [k*R +: R]
//  mode      in   2*N_CH    per ch: 00 bypass, 01 LP, 10 HP, 11 hold
//  tau       in   6*N_CH    per-ch shift; values > TAU_MAX are clamped to TAU_MAX
//  clr       in   N_CH      per-ch pulse: zero accumulator and sat flag
//  out_valid out  1         one-cycle pulse: out_data updated
//  out_data  out  N_CH*R    packed signed results, held between pulses
//  sat_flag  out  N_CH      sticky per-ch saturation indicator
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, out_valid=0, out_data=0, sat_flag=0, all acc=0.
//  - FSM IDLE -> RUN -> DONE. in_ready=1 in IDLE and DONE, 0 in RUN.
//  - Accept on in_valid&&in_ready: latch in_data, mode, tau (clamped); ch=0; go RUN.
//  - RUN: one channel per cycle, ch 0..N_CH-1; after ch N_CH-1 go DONE.
//  - DONE lasts 1 cycle with out_valid=1; a new accept in DONE goes straight to RUN, else IDLE.
//  - Latency: accept edge E0 -> out_valid high in the cycle after edge E0+N_CH.
//  - Throughput with in_valid held high: 1 vector per N_CH+1 cycles.
//  - Per-channel update (x=sample, a=acc[ch], t=clamped tau, all signed, arithmetic shifts):
//    LP:  a' = sat_S(a + x - (a>>>t)); y = sat_R(a'>>>t)
//    HP:  a' as LP; y = sat_R(x - (a'>>>t))
//    bypass: a' = x<<<t (bumpless preload for a later switch to LP/HP); y = x
//    hold: a' = a; y = previous out_data[ch]
//  - sat_S clamps to S-bit min/max; sat_R clamps to [-2**(R-1), 2**(R-1)-1].
//  - Either clamp active sets sat_flag[ch] (sticky).
//  - tau=0 with LP: y=x the same sample; with HP: y=0.
//  - clr[k] in any cycle: acc[k]=0, sat_flag[k]=0. clr wins over a same-cycle update of ch k (y still written).
//  - mode/tau changes take effect only at the next accept.
//  - rst mid-RUN: abort; no out_valid; all state returns to reset values.
// TESTING (R=14, N_CH=4, S=58)
//  1 LP: ch0 mode=01 tau=2, x=1000 repeatedly from reset -> y=250,437,578,...; converges to 1000.
//  2 HP: ch1 mode=10 tau=2, x=1000 from reset -> y=750,563,422,...; decays to 0.
//  3 Bumpless + saturation: ch2 bypass tau=10, x=8191 once; then HP, x=-8192
//    -> a'=8371201, lp=8175; y clamps to -8192; sat_flag[2]=1; clr[2] clears it.
//  4 Hold: ch3 in LP at y=578, then mode=11 for 3 vectors with varying x -> y stays 578, acc unchanged.
//  5 Handshake: in_valid held high -> accepts every 5 cycles; in_ready=0 during the 4 RUN cycles;
//    out_valid 1-cycle pulses; tau=63 behaves as tau=42.
//  6 Reset/clear: rst in 2nd RUN cycle -> no out_valid, out_data=0, in_ready=1 next cycle;
//    clr[0] coincident with ch0 update -> acc[0]=0.

Source files
------------

// File: rtl/iir1_mux_filter.sv
// iir1_mux_filter: time-multiplexed first-order shift IIR bank.
// One shared datapath walks the channels of each accepted vector.
module iir1_mux_filter #(
   parameter int R    = 14,
   parameter int N_CH = 4,
   parameter int S    = 58
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_CH*R-1:0] in_data,
   input  logic [2*N_CH-1:0] mode,
   input  logic [6*N_CH-1:0] tau,
   input  logic [N_CH-1:0]   clr,
   output logic              out_valid,
   output logic [N_CH*R-1:0] out_data,
   output logic [N_CH-1:0]   sat_flag
);

   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int S1 = S + 1;
   localparam int S2 = S + 2;

   localparam logic [5:0]    TAU_MAX = 6'(S - R - 2);
   localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);

   localparam logic signed [S-1:0] S_MAX = {1'b0, {(S-1){1'b1}}};
   localparam logic signed [S-1:0] S_MIN = {1'b1, {(S-1){1'b0}}};
   localparam logic signed [R-1:0] R_MAX = {1'b0, {(R-1){1'b1}}};
   localparam logic signed [R-1:0] R_MIN = {1'b1, {(R-1){1'b0}}};

   localparam logic [1:0] M_BYP  = 2'b00;
   localparam logic [1:0] M_LP   = 2'b01;
   localparam logic [1:0] M_HP   = 2'b10;
   localparam logic [1:0] M_HOLD = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t               state;
   logic [CW-1:0]        ch;
   logic signed [R-1:0]  x_q [N_CH];
   logic [1:0]           m_q [N_CH];
   logic [5:0]           t_q [N_CH];
   logic signed [S-1:0]  acc [N_CH];
   logic signed [R-1:0]  y_q [N_CH];

   logic                 accept;

   logic signed [R-1:0]  x_c;
   logic signed [S-1:0]  a_c;
   logic [5:0]           t_c;
   logic [1:0]           m_c;
   logic signed [S-1:0]  a_sh;
   logic signed [S2-1:0] sum_w;
   logic signed [S-1:0]  lp_a;
   logic                 sat_s;
   logic signed [S-1:0]  lp;
   logic signed [S1-1:0] lp_w;
   logic signed [S1-1:0] hp_w;
   logic signed [S-1:0]  a_new;
   logic signed [R-1:0]  y_new;
   logic                 sat_any;

   function automatic logic over_r(input logic signed [S1-1:0] v);
      return (v > S1'(R_MAX)) || (v < S1'(R_MIN));
   endfunction

   function automatic logic signed [R-1:0] clamp_r(
      input logic signed [S1-1:0] v
   );
      logic signed [R-1:0] r;
      if (v > S1'(R_MAX))
         r = R_MAX;
      else if (v < S1'(R_MIN))
         r = R_MIN;
      else
         r = v[R-1:0];
      return r;
   endfunction

   assign accept = in_valid && in_ready;

   // Sequencer: accept a vector, step one channel per cycle, flag done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ch        <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         for (int k = 0; k < N_CH; k++) begin
            x_q[k] <= '0;
            m_q[k] <= '0;
            t_q[k] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state    <= RUN;
                  in_ready <= 1'b0;
                  ch       <= '0;
               end else begin
                  state    <= IDLE;
               end
            end
            RUN: begin
               if (ch == CH_LAST) begin
                  state     <= DONE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b1;
               end else begin
                  ch <= ch + CW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
         if (accept) begin
            for (int k = 0; k < N_CH; k++) begin
               x_q[k] <= in_data[k*R +: R];
               m_q[k] <= mode[k*2 +: 2];
               t_q[k] <= (tau[k*6 +: 6] > TAU_MAX) ?
                         TAU_MAX : tau[k*6 +: 6];
            end
         end
      end
   end

   // Shared update for the channel selected by ch.
   always_comb begin
      x_c     = x_q[ch];
      a_c     = acc[ch];
      t_c     = t_q[ch];
      m_c     = m_q[ch];
      a_sh    = a_c >>> t_c;
      sum_w   = S2'(a_c) + S2'(x_c) - S2'(a_sh);
      sat_s   = 1'b0;
      lp_a    = sum_w[S-1:0];
      if (sum_w > S2'(S_MAX)) begin
         lp_a  = S_MAX;
         sat_s = 1'b1;
      end else if (sum_w < S2'(S_MIN)) begin
         lp_a  = S_MIN;
         sat_s = 1'b1;
      end
      lp      = lp_a >>> t_c;
      lp_w    = S1'(lp);
      hp_w    = S1'(x_c) - lp_w;
      a_new   = a_c;
      y_new   = y_q[ch];
      sat_any = 1'b0;
      unique case (m_c)
         M_BYP: begin
            a_new = S'(x_c) <<< t_c;
            y_new = x_c;
         end
         M_LP: begin
            a_new   = lp_a;
            y_new   = clamp_r(lp_w);
            sat_any = sat_s | over_r(lp_w);
         end
         M_HP: begin
            a_new   = lp_a;
            y_new   = clamp_r(hp_w);
            sat_any = sat_s | over_r(hp_w);
         end
         M_HOLD: begin
            a_new = a_c;
         end
         default: begin
            a_new = a_c;
         end
      endcase
   end

   // Per-channel state; a clear pulse beats a same-cycle update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_CH; k++) begin
            acc[k]      <= '0;
            y_q[k]      <= '0;
            sat_flag[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (state == RUN && ch == CW'(k)) begin
               acc[k] <= a_new;
               y_q[k] <= y_new;
               if (sat_any)
                  sat_flag[k] <= 1'b1;
            end
            if (clr[k]) begin
               acc[k]      <= '0;
               sat_flag[k] <= 1'b0;
            end
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_out
      assign out_data[g*R +: R] = y_q[g];
   end

endmodule
